button_pulse_gen: RTL
=====================

# button_pulse_gen

Conditions the two raw board push-buttons used for field selection into clean single-cycle increment/decrement pulses. It synchronises and debounces each button, emits one pulse per press, and adds auto-repeat while a button is held. Its outputs drive the `i_sel_inc_pulse` / `i_sel_dec_pulse` inputs of `sel_control` directly, one stage upstream of it.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronised samples required to accept a level change (5 ms at 100 MHz). Minimum 2.
- `REPEAT_DELAY`, 50000000: cycles from the initial press pulse to the first repeat pulse. Minimum 2.
- `REPEAT_RATE`, 20000000: cycles between subsequent repeat pulses. Minimum 2.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.
- `BTN_ACTIVE_LOW`, 1: 1 means a raw input of 0 is "pressed".
- `i_clk`, in, 1: system clock. All logic is on the rising edge.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_btn_inc`, in, 1: raw asynchronous increment button.
- `i_btn_dec`, in, 1: raw asynchronous decrement button.
- `o_inc_pulse`, out, 1: one-cycle increment pulse, registered.
- `o_dec_pulse`, out, 1: one-cycle decrement pulse, registered.
- `o_inc_level`, out, 1: debounced increment state, 1 = pressed, registered.
- `o_dec_level`, out, 1: debounced decrement state, 1 = pressed, registered.

## Operation
Each channel (inc, dec) is identical and independent, apart from the arbitration rule below.

- **Synchroniser:** two-flop synchroniser on the raw input. Polarity is normalised after the second flop, so pressed = 1. Flops reset to the released level.
- **Debounce:**
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
  - The counter clears whenever the synchronised value equals `o_*_level`.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, `o_*_level` takes the synchronised value and the counter clears.
  - Any mismatch-then-match glitch restarts the count.
- **Repeat FSM, per channel.** States are IDLE, DELAY and REPEAT.
  - IDLE: when the level rises, emit a pulse, clear the repeat counter, and go to DELAY.
  - DELAY: the counter counts up. At `REPEAT_DELAY-1`, emit a pulse, clear the counter, and go to REPEAT. If `REPEAT_EN`=0, DELAY holds with no pulse until release.
  - REPEAT: at `REPEAT_RATE-1`, emit a pulse and clear the counter.
  - From DELAY or REPEAT, a falling level returns the FSM to IDLE with the counter cleared and no pulse. Release never produces a pulse.
  - The repeat counter width is `$clog2` of the larger of `REPEAT_DELAY` and `REPEAT_RATE`.
- **Arbitration:**
  - A channel's pulse is suppressed in any cycle where the other channel's `o_*_level` is 1.
  - The FSMs and counters keep running while suppressed.
  - `o_inc_pulse` and `o_dec_pulse` are never high in the same cycle.
- **Reset:**
  - `i_reset_n` low immediately forces all outputs to 0, FSMs to IDLE, and all counters to 0.
  - A button still held when reset is released is treated as a new press after full debounce.

## Timing
- Reset values: `o_inc_pulse`=0, `o_dec_pulse`=0, `o_inc_level`=0, `o_dec_level`=0.
- Let the raw input change to a stable value before edge 1. `o_*_level` changes after edge `DEBOUNCE_CYCLES+2`: 2 synchroniser edges plus the debounce count.
- The press pulse is high for exactly one cycle, after the edge following the level rise, i.e. edge `DEBOUNCE_CYCLES+3`.
- The first repeat pulse comes `REPEAT_DELAY` cycles after the press pulse. Later repeat pulses are spaced by `REPEAT_RATE` cycles.
- The level falls `DEBOUNCE_CYCLES+2` edges after a stable release. No pulse is generated at or after that edge.
- A press shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no level change and no pulse.
- Reset deassertion is synchronised by the system. The block needs no extra cycles after reset.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8, `BTN_ACTIVE_LOW`=1, 4 ns clock.

- **Reset:** hold `i_reset_n`=0 with buttons released (1) -> all four outputs 0. Assert reset mid-cycle -> outputs clear without waiting for a clock edge.
- **Clean short press:** drive `i_btn_inc`=0 for 15 cycles, then release -> `o_inc_level` rises at edge 6 and `o_inc_pulse` is high at edge 7 only. Exactly one pulse in total, none on release; `o_dec_*` stays 0.
- **Bounce rejection:** toggle `i_btn_dec` every 2 cycles for 40 cycles, then leave it released -> `o_dec_level` stays 0 and there are zero pulses.
- **Auto-repeat:** hold `i_btn_inc`=0 for 70 cycles after the press pulse at cycle P -> pulses at P, P+20, P+28, P+36, P+44, P+52, P+60, P+68, each one cycle wide. With `REPEAT_EN`=0 -> only the pulse at P.
- **Both pressed:** press inc, then press dec 10 cycles later, hold both 40 cycles, then release dec -> no pulse on either output while both levels are 1, and never both pulses in the same cycle. Inc repeat pulses resume on its existing 8-cycle cadence once `o_dec_level` falls.
- **Reset mid-hold:** hold `i_btn_inc`=0 in REPEAT, pulse `i_reset_n` low for 3 cycles -> outputs go to 0 immediately. After release, a new press pulse arrives 7 edges after reset deassertion, then repeats at +20.

Source files
------------

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced push-button to inc/dec pulse generator with auto-repeat

module button_pulse_gen_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000,
    parameter int REPEAT_EN       = 1,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic block,
    output logic level,
    output logic level_next,
    output logic pulse
);

    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
    localparam logic RAW_RELEASED = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic            pressed;
    logic [DW-1:0]   db_cnt;
    logic [RW-1:0]   rpt_cnt;
    logic            fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RAW_RELEASED;
            sync2 <= RAW_RELEASED;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ RAW_RELEASED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (pressed == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= pressed;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Level as it will be after this edge; lets pulses be gated by the level they coexist with.
    assign level_next = (pressed != level && db_cnt == DB_LAST) ? pressed : level;

    always_comb begin
        fire = 1'b0;
        case (state)
            ST_IDLE:   fire = level;
            ST_DELAY:  fire = level && (REPEAT_EN != 0) && (rpt_cnt == RD_LAST);
            ST_REPEAT: fire = level && (rpt_cnt == RR_LAST);
            default:   fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            // Suppression only masks the output; the cadence keeps running underneath.
            pulse <= fire && level_next && !block;
            case (state)
                ST_IDLE: begin
                    rpt_cnt <= '0;
                    if (level) state <= ST_DELAY;
                end
                ST_DELAY: begin
                    if (!level) begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rpt_cnt == RD_LAST) begin
                            state   <= ST_REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!level) begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == RR_LAST) begin
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

endmodule

module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000,
    parameter int REPEAT_EN       = 1,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn_inc,
    input  logic i_btn_dec,
    output logic o_inc_pulse,
    output logic o_dec_pulse,
    output logic o_inc_level,
    output logic o_dec_level
);

    logic inc_level_next;
    logic dec_level_next;

    button_pulse_gen_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_inc (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .btn       (i_btn_inc),
        .block     (dec_level_next),
        .level     (o_inc_level),
        .level_next(inc_level_next),
        .pulse     (o_inc_pulse)
    );

    button_pulse_gen_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (REPEAT_EN),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_dec (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .btn       (i_btn_dec),
        .block     (inc_level_next),
        .level     (o_dec_level),
        .level_next(dec_level_next),
        .pulse     (o_dec_pulse)
    );

endmodule
